rr_arbiter: RTL
===============

Name: rr_arbiter

Overview:
- Round-robin arbiter sharing one downstream resource among N requesters.
- Uses a rotating-priority encoder to pick the winner and issues a registered one-hot grant plus an encoded grant ID.
- Holds the grant until the owner drops its request, then rotates priority so the next requester in line wins.
- Sits between request sources and the shared datapath; gnt_id drives the datapath select mux.

Parameters:
- N, 4, number of requesters; must be ≥2 and a power of 2.
- ID_W, $clog2(N), localparam giving the width of gnt_id; not overridable.
- MAX_HOLD, 8, maximum grant cycles before a forced revoke; used only with ARB_TIMEOUT_EN; must be ≥1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state immediately.
- req  input  N  per-requester request; the requester holds it high for as long as it uses the resource.
- gnt  output  N  one-hot grant, registered.
- gnt_id  output  ID_W  binary index of the granted requester; 0 when idle.
- busy  output  1  high while any grant is active.
- revoke  output  1  one-cycle pulse when a grant is forcibly removed by timeout; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset values:
  - gnt=0, gnt_id=0, busy=0, revoke=0.
  - state=IDLE, ptr=0, hold_cnt=0.
- ptr is the highest-priority index. Search order is ptr, ptr+1, …, ptr+N-1, all mod N.
- State IDLE:
  - If req==0, stay in IDLE.
  - Else at the next edge, grant the first set bit in search order.
  - Then gnt←onehot(w), gnt_id←w, busy←1, state←GRANT.
  - Request-to-grant latency is exactly 1 cycle.
- State GRANT, owner o:
  - While req[o]=1, the grant is held and other requests are ignored.
  - Release happens at an edge where req[o]=0. At that edge ptr←(o+1) mod N.
  - At the same edge, search req with bit o masked, starting from (o+1) mod N:
    - If a winner w is found, grant w directly with no idle bubble (GRANT→GRANT).
    - If none, go to IDLE with gnt=0, gnt_id=0, busy=0.
- Fairness: with all requests continuously asserted and each owner releasing after its use, grants cycle o, o+1, … mod N.
- Requests may rise or fall in any cycle. A non-owner request that drops before being granted is simply never granted; there is no latching.
- Grant outputs change only on clock edges and are always one-hot or zero. Never more than one bit of gnt is set.
- Reset mid-grant: all outputs go to 0 asynchronously. After reset release, arbitration restarts from ptr=0.
- ptr wraps from N-1 to 0.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt counts grant cycles for the current owner and clears on every new grant.
  - When hold_cnt reaches MAX_HOLD-1 while req[o]=1, the next edge treats the owner as released: rotate and re-arbitrate with o masked.
  - If no other requester is pending at that point, the grant is retained and hold_cnt saturates. revoke does not pulse.
  - When the grant actually moves away from a still-requesting owner, revoke=1 for that one cycle.
- Undefined: the grant is held indefinitely; hold_cnt logic is absent; revoke is tied to 0.

Decomposition:
- Package arb_pkg holds:
  - the state typedef {IDLE, GRANT};
  - default N and MAX_HOLD constants.
- Sub-module rr_prio_enc holds the pure combinational rotating priority encoder.
  - Inputs: req, mask, ptr.
  - Outputs: found, idx.
  - Instantiated once in rr_arbiter.

Test Plan:
1. Reset/idle:
   - Stimulus: assert rst mid-cycle with req=4'b1111.
   - Response: gnt=0, gnt_id=0, busy=0 immediately. After deassertion, next edge gives gnt=4'b0001, gnt_id=0.
2. Single request:
   - Stimulus: req=4'b0100 from idle.
   - Response: gnt=4'b0100, gnt_id=2 one cycle later. Drop req → gnt=0 and busy=0 at the next edge, ptr=3.
3. Round-robin rotation:
   - Stimulus: req=4'b1111, each owner drops its bit for one cycle after 2 cycles of grant.
   - Response: gnt_id sequence 0,1,2,3,0 with no idle cycles between grants.
4. Wrap and skip:
   - Stimulus: ptr=3 (owner 2 released) with req=4'b0011.
   - Response: next grant goes to 0, then 1. Requester 3 is skipped because it is not requesting.
5. Late requester:
   - Stimulus: owner 0 holds while req[1] pulses high for 1 cycle and drops.
   - Response: requester 1 is never granted; the grant stays on 0.
6. ARB_TIMEOUT_EN, MAX_HOLD=8:
   - Stimulus: req[0] held permanently, req[1] asserts at cycle 3 of the grant.
   - Response: after 8 grant cycles gnt moves to 4'b0010 and revoke pulses once. With req[1]=0 throughout, gnt stays 4'b0001 and revoke stays 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin arbiter slice.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_N_DEF        = 4;
  localparam int ARB_MAX_HOLD_DEF = 8;

endpackage

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: first unmasked request at or after ptr, wrapping mod N.
// Purely combinational, zero latency; no flow control.
module rr_prio_enc
  import arb_pkg::*;
#(
  parameter  int N    = ARB_N_DEF,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    mask,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] idx
);

  logic [N-1:0] w_eff;

  assign w_eff = req & ~mask;

  // Walk from the farthest slot back to ptr so the nearest candidate is written last.
  always_comb begin
    logic [ID_W-1:0] w_cand;
    found  = 1'b0;
    idx    = '0;
    w_cand = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_cand = ptr + ID_W'(i);
      if (w_eff[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, registered one-hot grant one cycle after request; owner holds until it drops req.
// ARB_TIMEOUT_EN adds a MAX_HOLD-cycle forced revoke when another requester is waiting.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter  int N        = ARB_N_DEF,
  parameter  int MAX_HOLD = ARB_MAX_HOLD_DEF,
  localparam int ID_W     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            busy,
  output logic            revoke
);

  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("rr_arbiter: N must be a power of 2 and at least 2");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("rr_arbiter: MAX_HOLD must be at least 1");
  end

  arb_state_t      r_state;
  arb_state_t      w_nxt_state;
  logic [ID_W-1:0] r_owner;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_nxt_owner;
  logic [ID_W-1:0] w_nxt_ptr;
  logic [ID_W-1:0] w_srch_ptr;
  logic [N-1:0]    w_mask;
  logic            w_found;
  logic [ID_W-1:0] w_win;
  logic            w_owner_req;
  logic            w_expire;
  logic            w_release;
  logic            w_new_grant;

  rr_prio_enc #(.N(N)) u_enc (
    .req   (req),
    .mask  (w_mask),
    .ptr   (w_srch_ptr),
    .found (w_found),
    .idx   (w_win)
  );

  assign w_owner_req = req[r_owner];
  assign w_release   = !w_owner_req || w_expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_owner <= w_nxt_owner;
      r_ptr   <= w_nxt_ptr;
    end
  end

  // While granted, the search excludes the owner and starts just past it.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_owner = r_owner;
    w_nxt_ptr   = r_ptr;
    w_new_grant = 1'b0;
    w_srch_ptr  = r_ptr;
    w_mask      = '0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_nxt_state = GRANT;
          w_nxt_owner = w_win;
          w_new_grant = 1'b1;
        end
      end
      GRANT: begin
        w_srch_ptr = r_owner + ID_W'(1);
        w_mask     = N'(1) << r_owner;
        if (w_release) begin
          if (w_found) begin
            w_nxt_owner = w_win;
            w_nxt_ptr   = r_owner + ID_W'(1);
            w_new_grant = 1'b1;
          end else if (!w_owner_req) begin
            w_nxt_state = IDLE;
            w_nxt_ptr   = r_owner + ID_W'(1);
          end
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    busy   = 1'b0;
    if (r_state == GRANT) begin
      gnt[r_owner] = 1'b1;
      gnt_id       = r_owner;
      busy         = 1'b1;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int              HC_W      = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

  logic [HC_W-1:0] r_hold_cnt;
  logic            r_revoke;

  assign w_expire = (r_hold_cnt == HOLD_LAST);
  assign revoke   = r_revoke;

  // Counter saturates at its last value so a lone owner keeps the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= '0;
      r_revoke   <= 1'b0;
    end else begin
      if (w_new_grant) begin
        r_hold_cnt <= '0;
      end else if (r_state == GRANT && !w_expire) begin
        r_hold_cnt <= r_hold_cnt + HC_W'(1);
      end
      r_revoke <= (r_state == GRANT) && w_expire && w_owner_req && w_found;
    end
  end
`else
  assign w_expire = 1'b0;
  assign revoke   = 1'b0;
`endif

endmodule
